// File: rtl/scanout_pipeline.sv
// scanout_pipeline: ping-pong line buffers, integer upscale, palette lookup.
// Define SCANOUT_BG_EN to show bg_rgb for colour index 0.
module scanout_pipeline #(
  parameter int H_RES       = 640,
  parameter int CORDW       = 10,
  parameter int IDX_W       = 8,
  parameter int PAL_W       = 24,
  parameter int OUT_W       = 4,
  parameter int SCALE_LOG2  = 0,
  parameter int PAL_LATENCY = 1,
  parameter bit SYNC_IDLE   = 1'b1,
  localparam int LINE_W     = H_RES >> SCALE_LOG2,
  localparam int AW         = $clog2(LINE_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [IDX_W-1:0] wr_data,
  input  logic             wr_done,
  output logic [IDX_W-1:0] pal_addr,
  input  logic [PAL_W-1:0] pal_data,
`ifdef SCANOUT_BG_EN
  input  logic [PAL_W-1:0] bg_rgb,
`endif
  output logic [OUT_W-1:0] vga_r,
  output logic [OUT_W-1:0] vga_g,
  output logic [OUT_W-1:0] vga_b,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             underrun,
  input  logic             underrun_clr,
  output logic             back_ready
);

  localparam int L = 2 + PAL_LATENCY;
  localparam logic [CORDW-1:0] SUB_MASK =
    CORDW'((1 << SCALE_LOG2) - 1);

  logic [IDX_W-1:0] ram0 [LINE_W];
  logic [IDX_W-1:0] ram1 [LINE_W];
  logic [IDX_W-1:0] rd_data;
  logic [CORDW-1:0] sx_line;
  logic [CORDW-1:0] last_sy;
  logic [AW-1:0]    rd_addr;
  logic             front_sel;
  logic             done_seen;
  logic             line_evt;
  logic             swap_slot;
  logic             done_any;
  logic             wr_ok;
  logic [L-1:0]     de_p;
  logic [L-1:0]     hs_p;
  logic [L-1:0]     vs_p;
  logic [PAL_W-1:0] pix_rgb;
  logic             unused_ok;

  assign sx_line = sx >> SCALE_LOG2;
  assign rd_addr = (de && 32'(sx) < H_RES) ? sx_line[AW-1:0] : '0;
  assign wr_ok   = wr_en && (32'(wr_addr) < LINE_W);

  assign line_evt  = sy != last_sy;
  assign swap_slot = line_evt && ((sy & SUB_MASK) == '0);
  assign done_any  = done_seen | wr_done;

  // front_sel = 1 means ram1 is scanned out and ram0 is the back line
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (front_sel) ram0[wr_addr] <= wr_data;
      else           ram1[wr_addr] <= wr_data;
    end
    rd_data <= front_sel ? ram1[rd_addr] : ram0[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_sy   <= '0;
      front_sel <= 1'b0;
      done_seen <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      last_sy <= sy;
      if (swap_slot) begin
        if (done_any) front_sel <= ~front_sel;
        done_seen <= 1'b0;
      end else begin
        done_seen <= done_any;
      end
      if (swap_slot && !done_any) underrun <= 1'b1;
      else if (underrun_clr)      underrun <= 1'b0;
    end
  end

  assign back_ready = ~done_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_p     <= '0;
      hs_p     <= {L{SYNC_IDLE}};
      vs_p     <= {L{SYNC_IDLE}};
      pal_addr <= '0;
      vga_r    <= '0;
      vga_g    <= '0;
      vga_b    <= '0;
    end else begin
      de_p     <= {de_p[L-2:0], de};
      hs_p     <= {hs_p[L-2:0], hsync_in};
      vs_p     <= {vs_p[L-2:0], vsync_in};
      pal_addr <= de_p[0] ? rd_data : '0;
      if (de_p[L-2]) begin
        vga_r <= pix_rgb[8*2+7 -: OUT_W];
        vga_g <= pix_rgb[8*1+7 -: OUT_W];
        vga_b <= pix_rgb[8*0+7 -: OUT_W];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

  assign vga_hsync = hs_p[L-1];
  assign vga_vsync = vs_p[L-1];

`ifdef SCANOUT_BG_EN
  // index-0 flag rides alongside the palette read
  logic [PAL_LATENCY-1:0] zero_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_p <= '0;
    end else begin
      zero_p[0] <= de_p[0] && (rd_data == '0);
      for (int i = 1; i < PAL_LATENCY; i++)
        zero_p[i] <= zero_p[i-1];
    end
  end

  assign pix_rgb = zero_p[PAL_LATENCY-1] ? bg_rgb : pal_data;
`else
  assign pix_rgb = pal_data;
`endif

  assign unused_ok = ^{pix_rgb, sx_line, de_p[L-1]};

endmodule
